// File: rtl/dense_neuron_sequencer.sv
// Dense layer sequencer: bias fetch, N_IN-term saturating MAC, ReLU,
// one activation per neuron on a valid/ready stream.
module dense_neuron_sequencer #(
    parameter  int N_IN      = 16,
    parameter  int N_OUT     = 8,
    parameter  int FRAC_BITS = 8,
    localparam int XAW = ($clog2(N_IN) < 1) ? 1 : $clog2(N_IN),
    localparam int WAW = ($clog2(N_IN*N_OUT) < 1) ? 1 : $clog2(N_IN*N_OUT),
    localparam int BAW = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [XAW-1:0] x_addr,
    input  logic [15:0]    x_data,
    output logic [WAW-1:0] w_addr,
    input  logic [15:0]    w_data,
    output logic [BAW-1:0] b_addr,
    input  logic [31:0]    b_data,
    output logic           act_valid,
    input  logic           act_ready,
    output logic [31:0]    act_data,
    output logic [BAW-1:0] act_index
);

    typedef enum logic [1:0] {S_IDLE, S_BIAS, S_MAC, S_OUT} state_t;

    localparam logic [31:0] NI = 32'(N_IN);

    state_t              r_state;
    state_t              w_next;
    logic [BAW-1:0]      r_j;
    logic [XAW-1:0]      r_i;
    logic [31:0]         r_acc;
    logic                r_done;

    logic                w_last_i;
    logic                w_last_j;
    logic                w_hs;
    logic [XAW-1:0]      w_xi;
    logic signed [15:0]  w_x;
    logic signed [15:0]  w_w;
    logic signed [31:0]  w_mul;
    logic signed [31:0]  w_prod;
    logic signed [31:0]  w_base;
    logic signed [32:0]  w_sum;
    logic [31:0]         w_sat;

    assign w_last_i = (r_i == XAW'(N_IN - 1));
    assign w_last_j = (r_j == BAW'(N_OUT - 1));
    assign w_hs     = (r_state == S_OUT) && act_ready;

    // Product is floored by the arithmetic shift; sum widened by one bit to detect overflow
    assign w_x    = x_data;
    assign w_w    = w_data;
    assign w_mul  = w_x * w_w;
    assign w_prod = w_mul >>> FRAC_BITS;
    assign w_base = (r_i == '0) ? $signed(b_data) : $signed(r_acc);
    assign w_sum  = {w_base[31], w_base} + {w_prod[31], w_prod};

    always_comb begin
        w_sat = w_sum[31:0];
        if (w_sum[32] != w_sum[31])
            w_sat = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    // Prefetch element i+1 while consuming i; hold on the last element
    always_comb begin
        w_xi = '0;
        if (r_state == S_MAC)
            w_xi = w_last_i ? r_i : r_i + 1'b1;
    end

    assign x_addr = w_xi;
    assign w_addr = WAW'(32'(r_j) * NI + 32'(w_xi));
    assign b_addr = r_j;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_BIAS;
            S_BIAS:  w_next = S_MAC;
            S_MAC:   if (w_last_i) w_next = S_OUT;
            S_OUT:   if (act_ready) w_next = w_last_j ? S_IDLE : S_BIAS;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_i     <= '0;
            r_acc   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_hs && w_last_j;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_j <= '0;
                        r_i <= '0;
                    end
                end
                S_BIAS: r_i <= '0;
                S_MAC: begin
                    r_acc <= w_sat;
                    if (!w_last_i)
                        r_i <= r_i + 1'b1;
                end
                S_OUT: begin
                    if (act_ready)
                        r_j <= w_last_j ? '0 : r_j + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign act_valid = (r_state == S_OUT);
    assign act_data  = (act_valid && !r_acc[31]) ? r_acc : 32'h0;
    assign act_index = act_valid ? r_j : '0;

endmodule

// File: tb/tb_dense_neuron_sequencer.sv
// Scoreboard bench for dense_neuron_sequencer (N_IN=4, N_OUT=2, Q8).
module tb_dense_neuron_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  x_addr;
    logic [15:0] x_data;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic [0:0]  b_addr;
    logic [31:0] b_data;
    logic        act_valid;
    logic        act_ready;
    logic [31:0] act_data;
    logic [0:0]  act_index;

    logic [15:0] xm [N_IN];
    logic [15:0] wm [N_IN*N_OUT];
    logic [31:0] bm [N_OUT];

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;

    dense_neuron_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .act_valid(act_valid),
        .act_ready(act_ready), .act_data(act_data), .act_index(act_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_data <= xm[x_addr];
        w_data <= wm[w_addr];
        b_data <= bm[b_addr];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    // Monitor: scoreboard pops, stall stability, done pulse timing
    initial begin
        logic        p_stall;
        logic        p_done;
        logic [31:0] p_data;
        logic [0:0]  p_idx;
        logic [1:0]  p_x;
        logic [2:0]  p_w;
        logic [0:0]  p_b;
        exp_t        e;
        p_stall = 1'b0;
        p_done  = 1'b0;
        p_data  = '0;
        p_idx   = '0;
        p_x     = '0;
        p_w     = '0;
        p_b     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_stall = 1'b0;
                p_done  = 1'b0;
            end else begin
                if (p_stall) begin
                    chk("stall_valid", 32'(act_valid), 32'd1);
                    chk("stall_data", act_data, p_data);
                    chk("stall_index", 32'(act_index), 32'(p_idx));
                    chk("stall_waddr", 32'(w_addr), 32'(p_w));
                    chk("stall_xaddr", 32'(x_addr), 32'(p_x));
                    chk("stall_baddr", 32'(b_addr), 32'(p_b));
                end
                if (act_valid && act_ready) begin
                    hs_cnt++;
                    if (act_index == 1'b1)
                        last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_act got %h idx %0d", act_data, act_index);
                    end else begin
                        e = exp_q.pop_front();
                        chk("act_index", 32'(act_index), e.idx);
                        chk("act_data", act_data, e.data);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_timing", cyc, last_hs_cyc + 1);
                    chk("done_width", 32'(p_done), 32'd0);
                end
                p_done  = done;
                p_stall = act_valid && !act_ready;
                p_data  = act_data;
                p_idx   = act_index;
                p_x     = x_addr;
                p_w     = w_addr;
                p_b     = b_addr;
            end
        end
    end

    task automatic load(input logic [15:0] x0, x1, x2, x3,
                        input logic [15:0] a0, a1, a2, a3,
                        input logic [15:0] c0, c1, c2, c3,
                        input logic [31:0] b0, b1);
        xm[0] = x0; xm[1] = x1; xm[2] = x2; xm[3] = x3;
        wm[0] = a0; wm[1] = a1; wm[2] = a2; wm[3] = a3;
        wm[4] = c0; wm[5] = c1; wm[6] = c2; wm[7] = c3;
        bm[0] = b0; bm[1] = b1;
    endtask

    task automatic load_basic();
        load(16'h0100, 16'h0100, 16'h0100, 16'h0100,
             16'h0100, 16'h0100, 16'h0100, 16'h0100,
             16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
             32'h100, 32'h0);
    endtask

    // Entered and left at posedge+#1
    task automatic do_layer(input string nm, input int stall, input bit extra,
                            input bit achk, input logic [31:0] e0, e1,
                            input int exp_lat);
        int bh, bd, t0, n, lat;
        exp_q.push_back('{32'd0, e0});
        exp_q.push_back('{32'd1, e1});
        bh = hs_cnt;
        bd = done_cnt;
        act_ready = (stall == 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        if (achk) begin
            for (int k = 0; k < 12; k++) begin
                if (k < 4 || (k >= 6 && k < 10)) begin
                    chk("x_addr", 32'(x_addr), (k < 4) ? k : k - 6);
                    chk("w_addr", 32'(w_addr), (k < 4) ? k : k - 2);
                end
                if (k == 0 || k == 6)
                    chk("b_addr", 32'(b_addr), k / 6);
                @(posedge clk); #1;
            end
        end
        if (extra) begin
            repeat (3) begin @(posedge clk); #1; end
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (stall > 0) begin
            n = 0;
            while (!act_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!act_valid) fail_now({nm, "_wait_valid"});
            repeat (stall - 1) begin @(posedge clk); #1; end
            @(posedge clk); #1;
            act_ready = 1'b1;
        end
        n = 0;
        while (done_cnt == bd && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == bd) fail_now({nm, "_wait_done"});
        repeat (20) begin @(posedge clk); #1; end
        lat = last_hs_cyc - t0 + 1;
        chk({nm, "_handshakes"}, hs_cnt - bh, 32'd2);
        chk({nm, "_dones"}, done_cnt - bd, 32'd1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_queue_left"}, exp_q.size(), 32'd0);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int bh;
        reset = 1'b1;
        start = 1'b0;
        act_ready = 1'b1;
        load_basic();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(act_valid), 32'd0);
        chk("rst_data", act_data, 32'd0);
        chk("rst_addr", {x_addr, w_addr, b_addr, act_index}, 32'd0);

        do_layer("basic", 0, 1'b0, 1'b1, 32'h500, 32'h0, 12);
        do_layer("stall", 5, 1'b0, 1'b0, 32'h500, 32'h0, 17);

        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
             16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
             16'h8001, 16'h8001, 16'h8001, 16'h8001,
             32'h7FFFFF00, 32'h80000000);
        do_layer("sat", 0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h0, 12);

        load(16'h0100, 16'h0200, 16'hFF00, 16'h0080,
             16'h0100, 16'h0100, 16'h0100, 16'h0100,
             16'h0000, 16'h0100, 16'h0000, 16'h0200,
             32'h0, 32'h10);
        do_layer("order", 0, 1'b0, 1'b0, 32'h280, 32'h310, 12);

        load(16'h0001, 16'h0001, 16'h0001, 16'h0001,
             16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'h0003, 16'h0003, 16'h0003, 16'h0003,
             32'h10, 32'h20);
        do_layer("floor", 0, 1'b0, 1'b0, 32'hC, 32'h20, 12);

        load_basic();
        do_layer("restart", 0, 1'b1, 1'b0, 32'h500, 32'h0, 12);

        exp_q.push_back('{32'd0, 32'h500});
        bh = hs_cnt;
        act_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(act_valid), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_data", act_data, 32'd0);
        chk("mrst_addr", {x_addr, w_addr, b_addr, act_index}, 32'd0);
        repeat (15) begin @(posedge clk); #1; end
        chk("mrst_handshakes", hs_cnt - bh, 32'd1);
        chk("mrst_queue_left", exp_q.size(), 32'd0);
        chk("mrst_still_idle", 32'(busy), 32'd0);
        exp_q.delete();

        do_layer("after_rst", 0, 1'b0, 1'b1, 32'h500, 32'h0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
